// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM-stage types and constants
package mips_pkg;
  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;
  localparam int WORD_ALIGN_BITS = 2;
endpackage

// File: rtl/mem2wb_reg.sv
// mem2wb_reg: MEM/WB pipeline register with bubble insertion and optional load-data capture
module mem2wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        load_rdata,
  input  logic [4:0]  write_reg_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rdata_in,
  input  logic        mem_to_reg_in,
  input  logic        data_c_in,
  output logic [4:0]  write_reg_wb,
  output logic [31:0] pc_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] read_data_wb,
  output logic        MemtoReg_wb,
  output logic        DataC_wb
);
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] pc_q, pc_d, alu_result_q, alu_result_d, read_data_q, read_data_d;
  logic        mem_to_reg_q, mem_to_reg_d, data_c_q, data_c_d;
  always_comb begin
    write_reg_d  = write_reg_in;
    pc_d         = pc_in;
    alu_result_d = alu_result_in;
    read_data_d  = load_rdata ? rdata_in : read_data_q;
    mem_to_reg_d = bubble ? 1'b0 : mem_to_reg_in;
    data_c_d     = bubble ? 1'b0 : data_c_in;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_reg_q  <= '0;
      pc_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      mem_to_reg_q <= 1'b0;
      data_c_q     <= 1'b0;
    end else begin
      write_reg_q  <= write_reg_d;
      pc_q         <= pc_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      mem_to_reg_q <= mem_to_reg_d;
      data_c_q     <= data_c_d;
    end
  end
  assign write_reg_wb  = write_reg_q;
  assign pc_wb         = pc_q;
  assign alu_result_wb = alu_result_q;
  assign read_data_wb  = read_data_q;
  assign MemtoReg_wb   = mem_to_reg_q;
  assign DataC_wb      = data_c_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage issuing req/ack data-memory accesses with stall, timeout and alignment checks
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  write_reg_mem,
  input  logic [31:0] pc_mem,
  input  logic        MemWrite_mem,
  input  logic        MemRead_mem,
  input  logic        MemtoReg_mem,
  input  logic        DataC_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [4:0]  write_reg_wb,
  output logic [31:0] pc_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] read_data_wb,
  output logic        MemtoReg_wb,
  output logic        DataC_wb,
  output logic        bus_err,
  output logic        misalign_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  mem_state_t  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic bus_err_q, bus_err_d, misalign_err_q, misalign_err_d;
  logic memop, aligned, misaligned, abort, complete, stall, bubble, load_rdata;
  always_comb begin
    memop          = MemRead_mem | MemWrite_mem;
    aligned        = memop & (alu_result_mem[WORD_ALIGN_BITS-1:0] == '0);
    misaligned     = memop & ~aligned;
    abort          = (state_q == MEM_WAIT) & ~dmem_ack & (count_q == CW'(TIMEOUT_CYCLES - 1));
    complete       = aligned & dmem_ack;
    stall          = aligned & ~dmem_ack & ~abort;
    bubble         = stall | misaligned | abort;
    load_rdata     = complete & MemRead_mem & ~MemWrite_mem;
    state_d        = (state_q == MEM_IDLE) ? (stall ? MEM_WAIT : MEM_IDLE)
                                           : ((dmem_ack | abort) ? MEM_IDLE : MEM_WAIT);
    count_d        = (state_d == MEM_WAIT) ? count_q + 1'b1 : '0;
    bus_err_d      = abort;
    misalign_err_d = misaligned;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= MEM_IDLE;
      count_q        <= '0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end
  // request stays up while the upstream registers are frozen on the same access
  assign dmem_req     = rst_n & aligned;
  assign dmem_we      = rst_n & aligned & MemWrite_mem;
  assign dmem_addr    = alu_result_mem;
  assign dmem_wdata   = write_data_mem;
  assign mem_stall    = rst_n & stall;
  assign bus_err      = bus_err_q;
  assign misalign_err = misalign_err_q;
  mem2wb_reg u_mem2wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (bubble),
    .load_rdata   (load_rdata),
    .write_reg_in (write_reg_mem),
    .pc_in        (pc_mem),
    .alu_result_in(alu_result_mem),
    .rdata_in     (dmem_rdata),
    .mem_to_reg_in(MemtoReg_mem),
    .data_c_in    (DataC_mem),
    .write_reg_wb (write_reg_wb),
    .pc_wb        (pc_wb),
    .alu_result_wb(alu_result_wb),
    .read_data_wb (read_data_wb),
    .MemtoReg_wb  (MemtoReg_wb),
    .DataC_wb     (DataC_wb)
  );
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MIPS pipeline MEM stage. Sits directly downstream of the EX/MEM pipeline register. It issues load/store requests to an external data memory over a req/ack handshake with variable latency, and holds the upstream pipeline while a request is outstanding. Results go into its own MEM/WB register, which feeds write-back.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max cycles a request may remain unacknowledged before abort (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- write_reg_mem  in  5  destination register from EX/MEM
- pc_mem  in  32  instruction PC
- MemWrite_mem  in  1  store
- MemRead_mem  in  1  load
- MemtoReg_mem  in  1  write-back selects memory data
- DataC_mem  in  1  register-write enable, carried to WB
- alu_result_mem  in  32  effective address / ALU result
- write_data_mem  in  32  store data
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ack  in  1  request complete this cycle
- dmem_rdata  in  32  load data, valid with dmem_ack
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers
- write_reg_wb, pc_wb, alu_result_wb  out  5/32/32  registered pass-through
- read_data_wb  out  32  captured load data
- MemtoReg_wb, DataC_wb  out  1 each  registered controls
- bus_err  out  1  one-cycle pulse: request timed out
- misalign_err  out  1  one-cycle pulse: misaligned access

## Operation
- memop = MemRead_mem | MemWrite_mem. If both are set, treat the access as a store.
- misaligned = memop & (alu_result_mem[1:0] != 0). A misaligned access issues no request. Next edge: misalign_err=1 and the WB register takes a bubble (DataC_wb=0). No stall.
- State machine, two states:
  - MEM_IDLE:
    - Aligned memop: drive dmem_req=1 combinationally, with dmem_we=MemWrite_mem, dmem_addr=alu_result_mem, dmem_wdata=write_data_mem.
    - dmem_ack the same cycle: complete, stay in IDLE.
    - No ack: go to MEM_WAIT with count=1.
  - MEM_WAIT: hold req/we/addr/wdata stable (upstream is frozen).
    - On ack: complete and go to IDLE.
    - Else if count==TIMEOUT_CYCLES-1: abort. Next edge: bus_err=1, WB bubble, go to IDLE.
    - Else count++.
- mem_stall = aligned memop & !dmem_ack & !abort_this_cycle, in either state.
- Complete: at the edge, the WB register loads all pass-through fields and read_data_wb<=dmem_rdata (loads only; stores leave read_data_wb unchanged) and DataC_wb<=DataC_mem.
- Non-memop: WB register loads the pass-through fields at the next edge. read_data_wb is unchanged. No stall.
- While stalled, the WB register loads a bubble every cycle: DataC_wb=0, MemtoReg_wb=0. Other fields are don't-care but are loaded with the current inputs.
- dmem_ack while no request is driven is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES)+1 bits, unsigned, never wraps.

## Timing
- Reset (rst_n=0 at an edge): state=MEM_IDLE, count=0, all *_wb outputs=0, bus_err=0, misalign_err=0.
  - dmem_req, dmem_we and mem_stall are combinational. They are forced 0 while rst_n=0.
  - Reset mid-WAIT abandons the request with no error pulse.
- Latency, EX/MEM input to WB output:
  - non-memop: 1 cycle
  - zero-wait access: 1 cycle
  - N-wait access: N+1 cycles, mem_stall high for N cycles
  - abort: TIMEOUT_CYCLES cycles
- Handshake: dmem_req stays high until the ack cycle or the abort cycle. It deasserts combinationally in the cycle after, unless a new memop is present.
- Back-to-back memops: the next request may be driven in the cycle immediately after ack.
- bus_err and misalign_err are registered, high exactly one cycle.

## Structure
- Shared package mips_pkg: mem_state_t {MEM_IDLE, MEM_WAIT}; constant WORD_ALIGN_BITS=2.
- Sub-module mem2wb_reg: MEM/WB register with synchronous active-low reset, a bubble input and a load-read-data input. The FSM and counter live in mem_access_stage.

## Test plan
- ALU op: alu_result_mem=0x1234, DataC_mem=1, no memop → next cycle alu_result_wb=0x1234, DataC_wb=1, mem_stall never high.
- Load, addr 0x40, ack after 3 wait cycles with rdata=0xDEADBEEF → mem_stall high 3 cycles, WB bubbles during them, then read_data_wb=0xDEADBEEF, MemtoReg_wb=1, DataC_wb=1.
- Zero-wait store, addr 0x80, wdata 0xA5A5A5A5, ack same cycle → dmem_we=1 one cycle, no stall, DataC_wb=0.
- Load addr 0x41 → no dmem_req, misalign_err one pulse, DataC_wb=0.
- Load with no ack, TIMEOUT_CYCLES=16 → mem_stall high 15 cycles, bus_err pulse, request dropped, pipeline resumes.
- rst_n low during the 2nd wait cycle → dmem_req=0 immediately, all outputs 0 next edge, no bus_err; a load following reset completes normally.
